lshift_pipe: RTL and testbench

Two-stage pipelined variable left shifter with valid/ready handshakes on both sides. It is the registered, back-pressurable front end for the combinational left-shift datapath. It accepts an operand and a shift amount per cycle and delivers `operand << amount`, truncated to the operand width, two cycles later. It also sits directly upstream of result consumers that may stall.

---
 rtl/lshift_pipe.sv | 129 ++++++++++++
 tb/tb_lshift_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lshift_pipe.sv
// lshift_pipe: two-stage pipelined logical left shifter with valid/ready handshakes on both sides.
// Define LSHIFT_PIPE_OVF_EN to build the overflow flag; otherwise out_ovf is tied low.
module lshift_pipe #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int S  = $clog2(WIDTH);
  localparam int K  = S / 2;
  // Always keep at least one amount bit above S so the zero-flag slice is never empty.
  localparam int AW = (AMT_W > S) ? AMT_W : S + 1;

  logic [AW-1:0]    w_amt;
  logic [K-1:0]     w_amt_lo;
  logic [S-K-1:0]   w_amt_hi;
  logic             w_zero;
  logic [WIDTH-1:0] w_s1_data;
  logic [WIDTH-1:0] w_s2_data;
  logic             w_s1_adv;
  logic             w_s2_adv;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [S-K-1:0]   r_s1_amt_hi;
  logic             r_s1_z;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;

  // Amount decode plus the low-bits shift (S1) and high-bits shift (S2) datapaths.
  always_comb begin
    w_amt     = AW'(in_amt);
    w_amt_lo  = w_amt[K-1:0];
    w_amt_hi  = w_amt[S-1:K];
    w_zero    = |w_amt[AW-1:S];
    w_s1_data = in_data << w_amt_lo;
    if (r_s1_z) begin
      w_s2_data = {WIDTH{1'b0}};
    end else begin
      w_s2_data = r_s1_data << {r_s1_amt_hi, {K{1'b0}}};
    end
  end

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

  // Stage 1 register: loads whenever the slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= {WIDTH{1'b0}};
      r_s1_amt_hi <= {(S-K){1'b0}};
      r_s1_z      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_data   <= w_s1_data;
      r_s1_amt_hi <= w_amt_hi;
      r_s1_z      <= w_zero;
    end
  end

  // Stage 2 register: drives the output side directly; frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= {WIDTH{1'b0}};
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_s2_data;
    end
  end

`ifdef LSHIFT_PIPE_OVF_EN
  logic w_s1_ovf;
  logic w_s2_ovf;
  logic r_s1_ovf;
  logic r_s2_ovf;

  // True when shifting d left by sh pushes any 1 bit past the top of the word.
  function automatic logic f_lost(input logic [WIDTH-1:0] d, input logic [S-1:0] sh);
    logic [2*WIDTH-1:0] ext;
    ext = {{WIDTH{1'b0}}, d} << sh;
    return |ext[2*WIDTH-1:WIDTH];
  endfunction

  // Overflow accumulates bits lost in S1, then those lost in S2 (all of them when zeroing).
  always_comb begin
    w_s1_ovf = f_lost(in_data, {{(S-K){1'b0}}, w_amt_lo});
    if (r_s1_z) begin
      w_s2_ovf = r_s1_ovf | (|r_s1_data);
    end else begin
      w_s2_ovf = r_s1_ovf | f_lost(r_s1_data, {r_s1_amt_hi, {K{1'b0}}});
    end
  end

  // Overflow flag registers, advancing in lockstep with the data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_ovf <= 1'b0;
      r_s2_ovf <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_ovf <= w_s1_ovf;
      end
      if (w_s2_adv) begin
        r_s2_ovf <= w_s2_ovf;
      end
    end
  end

  assign out_ovf = r_s2_ovf;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_lshift_pipe.sv
// Testbench for lshift_pipe: directed steps plus random traffic checked against a queue-based model.
module tb_lshift_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;

  typedef struct {
    logic [7:0] d;
    logic       o;
    int         acc;
  } item_t;

  item_t q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  lshift_pipe #(.WIDTH(8), .AMT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic shift on a wide integer, truncated to 8 bits.
  function automatic item_t model(input logic [7:0] d, input logic [7:0] a);
    item_t        it;
    logic [15:0]  full;
    it.acc = 0;
    if (a >= 8'd8) begin
      it.d = 8'h00;
      it.o = (d != 8'h00);
    end else begin
      full = {8'h00, d} << a;
      it.d = full[7:0];
      it.o = (full[15:8] != 8'h00);
    end
`ifndef LSHIFT_PIPE_OVF_EN
    it.o = 1'b0;
`endif
    return it;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then advance past the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [7:0] a,
                      input logic r, output bit acc);
    item_t it;
    bit    exp_rdy;
    bit    exp_ov;
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    out_ready = r;
    #1;
    exp_rdy = (q.size() < 2) || r;
    exp_ov  = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_ovf", 32'(out_ovf), 32'(q[0].o));
      if (r) begin
        void'(q.pop_front());
      end
    end
    acc = v && exp_rdy;
    if (acc) begin
      it     = model(d, a);
      it.acc = cyc;
      q.push_back(it);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input string tag);
    bit a;
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      step(1'b0, 8'h00, 8'h00, 1'b1, a);
      n++;
    end
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit         a;
    bit         pend;
    bit         pv;
    logic [7:0] pd;
    logic [7:0] pa;
    logic [7:0] bp_d [4];
    logic [7:0] bp_a [4];
    int         idx;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    in_amt    = 8'h00;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sweep 0x01 by 0..7 back-to-back.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h01, 8'(i), 1'b1, a);
      chk("sweep_accept", 32'(a), 32'd1);
    end
    drain("sweep");

    // Truncation, small and large amounts.
    step(1'b1, 8'ha5, 8'h07, 1'b1, a);
    step(1'b1, 8'ha5, 8'h01, 1'b1, a);
    step(1'b1, 8'h01, 8'h03, 1'b1, a);
    step(1'b1, 8'hff, 8'h08, 1'b1, a);
    step(1'b1, 8'hff, 8'h09, 1'b1, a);
    step(1'b1, 8'hff, 8'hff, 1'b1, a);
    step(1'b1, 8'h00, 8'hff, 1'b1, a);
    step(1'b1, 8'h5a, 8'h00, 1'b1, a);
    drain("trunc");

    // Backpressure: 4 requests against a stalled consumer for 5 cycles.
    bp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    bp_a = '{8'h01, 8'h02, 8'h03, 8'h04};
    idx  = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bp_d[idx], bp_a[idx], 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepts_while_stalled", 32'(idx), 32'd2);
    for (int i = 0; i < 20 && idx < 4; i++) begin
      step(1'b1, bp_d[idx], bp_a[idx], 1'b1, a);
      if (a) idx++;
    end
    chk("bp_all_sent", 32'(idx), 32'd4);
    drain("bp");

    // Reset mid-flight: takes effect between edges.
    step(1'b1, 8'h11, 8'h01, 1'b1, a);
    step(1'b1, 8'h22, 8'h02, 1'b1, a);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_ovf", 32'(out_ovf), 32'd0);
    q.delete();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h03, 8'h02, 1'b1, a);
    chk("postrst_accept", 32'(a), 32'd1);
    step(1'b0, 8'h00, 8'h00, 1'b1, a);
    chk("postrst_valid", 32'(out_valid), 32'd1);
    chk("postrst_data", 32'(out_data), 32'h0c);
    drain("postrst");

    // Random traffic with sources holding a refused request stable.
    pend = 1'b0;
    pv   = 1'b0;
    pd   = 8'h00;
    pa   = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      if (!pend) begin
        pv = ($urandom_range(0, 9) < 7);
        pd = 8'($urandom);
        pa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      end
      step(pv, pd, pa, ($urandom_range(0, 9) < 7), a);
      pend = pv && !a;
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
